writeback_arbiter: RTL and testbench

- Shares one register-file write port among the four execution-unit result streams: alu, fpu, sram (mem) and misc (rs232c/keyboard/sd).
- Sits between the execution units and register_manager.
- Each source gets a small FIFO; a round-robin arbiter drains them.
- Drives a stall back to the decoder freeze logic and a pending-write hazard query for the register-read stage.

---
 rtl/writeback_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_writeback_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Shares the single register-file write port among four result streams
//   (0 alu, 1 fpu, 2 mem, 3 misc). Each stream has its own FIFO. A
//   round-robin arbiter drains the FIFOs, one write per cycle in total.
//   The block also drives a stall back to the decoder and answers a
//   pending-write hazard query for the register-read stage.
// Ports:
//   clk, reset               clock; synchronous active-high reset
//   enable_*/addr_*/data_*/float_*   per-source write requests
//   write_enable/addr/data/float     registered register-file write port
//   stall                    registered; some FIFO is at or above STALL_LEVEL
//   pending                  some FIFO is non-empty, or a write is on the port
//   query_addr/query_float   register being read by the issue stage
//   query_hit                a matching write is queued or on the port
//   overflow                 sticky; a push was dropped because its FIFO was full
module writeback_arbiter #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned STALL_LEVEL = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_alu,
    input  logic        enable_fpu,
    input  logic        enable_mem,
    input  logic        enable_misc,
    input  logic [4:0]  addr_alu,
    input  logic [4:0]  addr_fpu,
    input  logic [4:0]  addr_mem,
    input  logic [4:0]  addr_misc,
    input  logic [31:0] data_alu,
    input  logic [31:0] data_fpu,
    input  logic [31:0] data_mem,
    input  logic [31:0] data_misc,
    input  logic        float_alu,
    input  logic        float_fpu,
    input  logic        float_mem,
    input  logic        float_misc,
    output logic        write_enable,
    output logic [4:0]  write_addr,
    output logic [31:0] write_data,
    output logic        write_float,
    output logic        stall,
    output logic        pending,
    input  logic [4:0]  query_addr,
    input  logic        query_float,
    output logic        query_hit,
    output logic        overflow
);
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW   = $clog2(DEPTH + 1);
    localparam int unsigned NSRC = 4;

    logic [NSRC-1:0]  src_en;
    logic [NSRC-1:0]  src_float;
    logic [4:0]       src_addr [NSRC];
    logic [31:0]      src_data [NSRC];

    logic [4:0]       q_addr  [NSRC][DEPTH];
    logic [31:0]      q_data  [NSRC][DEPTH];
    logic [DEPTH-1:0] q_float [NSRC];
    logic [DEPTH-1:0] q_valid [NSRC];
    logic [PW-1:0]    rd_ptr  [NSRC];
    logic [PW-1:0]    wr_ptr  [NSRC];
    logic [CW-1:0]    count   [NSRC];
    logic [CW-1:0]    count_next [NSRC];

    logic [1:0]       rr_ptr;
    logic [1:0]       gnt_idx;
    logic             gnt_any;
    logic [NSRC-1:0]  non_empty, accept, full, pop, push, drop;
    logic             stall_next;

    always_comb begin
        src_en       = {enable_misc, enable_mem, enable_fpu, enable_alu};
        src_float    = {float_misc, float_mem, float_fpu, float_alu};
        src_addr[0]  = addr_alu;
        src_addr[1]  = addr_fpu;
        src_addr[2]  = addr_mem;
        src_addr[3]  = addr_misc;
        src_data[0]  = data_alu;
        src_data[1]  = data_fpu;
        src_data[2]  = data_mem;
        src_data[3]  = data_misc;
    end

    always_comb begin
        non_empty  = '0;
        accept     = '0;
        full       = '0;
        pop        = '0;
        push       = '0;
        drop       = '0;
        gnt_any    = 1'b0;
        gnt_idx    = rr_ptr;
        stall_next = 1'b0;
        for (int unsigned s = 0; s < NSRC; s++) begin
            non_empty[s] = (count[s] != '0);
        end
        // Search starts at the round-robin pointer; the 2-bit sum wraps 3->0.
        for (int unsigned k = 0; k < NSRC; k++) begin
            if (!gnt_any && non_empty[rr_ptr + 2'(k)]) begin
                gnt_any = 1'b1;
                gnt_idx = rr_ptr + 2'(k);
            end
        end
        for (int unsigned s = 0; s < NSRC; s++) begin
            // Integer r0 is never written, so it is dropped before queuing.
            accept[s] = src_en[s] && ((src_addr[s] != '0) || src_float[s]);
            full[s]   = (count[s] == CW'(DEPTH));
            pop[s]    = gnt_any && (gnt_idx == 2'(s));
            push[s]   = accept[s] && (!full[s] || pop[s]);
            drop[s]   = accept[s] && full[s] && !pop[s];
            count_next[s] = count[s] + CW'(push[s]) - CW'(pop[s]);
            if (count_next[s] >= CW'(STALL_LEVEL)) begin
                stall_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned s = 0; s < NSRC; s++) begin
                rd_ptr[s]  <= '0;
                wr_ptr[s]  <= '0;
                count[s]   <= '0;
                q_valid[s] <= '0;
            end
            rr_ptr       <= '0;
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
            write_float  <= 1'b0;
            stall        <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            for (int unsigned s = 0; s < NSRC; s++) begin
                count[s] <= count_next[s];
                // When full, push and pop address the same slot; the
                // later set must win over the clear.
                if (pop[s]) begin
                    rd_ptr[s]                <= rd_ptr[s] + 1'b1;
                    q_valid[s][rd_ptr[s]]    <= 1'b0;
                end
                if (push[s]) begin
                    wr_ptr[s]                <= wr_ptr[s] + 1'b1;
                    q_valid[s][wr_ptr[s]]    <= 1'b1;
                end
            end
            if (|drop) begin
                overflow <= 1'b1;
            end
            stall        <= stall_next;
            write_enable <= gnt_any;
            if (gnt_any) begin
                write_addr  <= q_addr[gnt_idx][rd_ptr[gnt_idx]];
                write_data  <= q_data[gnt_idx][rd_ptr[gnt_idx]];
                write_float <= q_float[gnt_idx][rd_ptr[gnt_idx]];
                rr_ptr      <= gnt_idx + 2'd1;
            end
        end
    end

    // Payload storage needs no reset; q_valid and count qualify it.
    always_ff @(posedge clk) begin
        for (int unsigned s = 0; s < NSRC; s++) begin
            if (push[s]) begin
                q_addr[s][wr_ptr[s]]  <= src_addr[s];
                q_data[s][wr_ptr[s]]  <= src_data[s];
                q_float[s][wr_ptr[s]] <= src_float[s];
            end
        end
    end

    always_comb begin
        pending = (|non_empty) || write_enable;
    end

    always_comb begin
        query_hit = 1'b0;
        if ((query_addr != '0) || query_float) begin
            if (write_enable && (write_addr == query_addr) && (write_float == query_float)) begin
                query_hit = 1'b1;
            end
            for (int unsigned s = 0; s < NSRC; s++) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (q_valid[s][i] && (q_addr[s][i] == query_addr) &&
                        (q_float[s][i] == query_float)) begin
                        query_hit = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter
//   Directed-vector bench for writeback_arbiter. Stimulus pushes the
//   hand-ordered expected writes into a scoreboard queue; a monitor on the
//   falling edge pops and compares every write the DUT presents. Status
//   outputs are checked directly by the stimulus process.
module tb_writeback_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable_alu = 1'b0, enable_fpu = 1'b0, enable_mem = 1'b0, enable_misc = 1'b0;
    logic [4:0]  addr_alu = '0, addr_fpu = '0, addr_mem = '0, addr_misc = '0;
    logic [31:0] data_alu = '0, data_fpu = '0, data_mem = '0, data_misc = '0;
    logic        float_alu = 1'b0, float_fpu = 1'b0, float_mem = 1'b0, float_misc = 1'b0;
    logic        write_enable, write_float, stall, pending, query_hit, overflow;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [4:0]  query_addr = '0;
    logic        query_float = 1'b0;

    always #5 clk = ~clk;

    writeback_arbiter #(.DEPTH(4), .STALL_LEVEL(2)) dut (
        .clk(clk), .reset(reset),
        .enable_alu(enable_alu), .enable_fpu(enable_fpu),
        .enable_mem(enable_mem), .enable_misc(enable_misc),
        .addr_alu(addr_alu), .addr_fpu(addr_fpu), .addr_mem(addr_mem), .addr_misc(addr_misc),
        .data_alu(data_alu), .data_fpu(data_fpu), .data_mem(data_mem), .data_misc(data_misc),
        .float_alu(float_alu), .float_fpu(float_fpu), .float_mem(float_mem), .float_misc(float_misc),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .write_float(write_float), .stall(stall), .pending(pending),
        .query_addr(query_addr), .query_float(query_float), .query_hit(query_hit),
        .overflow(overflow)
    );

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        flt;
    } wr_t;

    wr_t sb[$];
    wr_t mon_exp;
    int  tests = 0;
    int  fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (write_enable === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h float %0b, expected no write",
                         write_addr, write_data, write_float);
            end else begin
                mon_exp = sb.pop_front();
                check("write_addr", 32'(write_addr), 32'(mon_exp.addr));
                check("write_data", write_data, mon_exp.data);
                check("write_float", 32'(write_float), 32'(mon_exp.flt));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enable_alu = 1'b0; enable_fpu = 1'b0; enable_mem = 1'b0; enable_misc = 1'b0;
    endtask

    task automatic push(input int s, input logic [4:0] a, input logic [31:0] d,
                        input logic f, input bit expect_out);
        case (s)
            0: begin enable_alu  = 1'b1; addr_alu  = a; data_alu  = d; float_alu  = f; end
            1: begin enable_fpu  = 1'b1; addr_fpu  = a; data_fpu  = d; float_fpu  = f; end
            2: begin enable_mem  = 1'b1; addr_mem  = a; data_mem  = d; float_mem  = f; end
            default: begin enable_misc = 1'b1; addr_misc = a; data_misc = d; float_misc = f; end
        endcase
        if (expect_out) sb.push_back(wr_t'{a, d, f});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60 && sb.size() != 0; i++) step();
        check({name, "_drain_left"}, 32'(sb.size()), 32'd0);
        step();
        step();
        check({name, "_pending_idle"}, 32'(pending), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step();
        do_reset();
        check("rst_we", 32'(write_enable), 32'd0);
        check("rst_addr", 32'(write_addr), 32'd0);
        check("rst_data", write_data, 32'd0);
        check("rst_float", 32'(write_float), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);

        // Single alu write: visible two edges after being sampled
        query_addr = 5'd5; query_float = 1'b0;
        push(0, 5'd5, 32'h1234_5678, 1'b0, 1'b1);
        step(); idle();
        check("t1_c1_we", 32'(write_enable), 32'd0);
        check("t1_c1_pending", 32'(pending), 32'd1);
        check("t1_c1_qhit", 32'(query_hit), 32'd1);
        step();
        check("t1_c2_we", 32'(write_enable), 32'd1);
        check("t1_c2_pending", 32'(pending), 32'd1);
        check("t1_c2_qhit", 32'(query_hit), 32'd1);
        query_float = 1'b1;
        #1;
        check("t1_qhit_other_file", 32'(query_hit), 32'd0);
        query_float = 1'b0;
        step();
        check("t1_c3_we", 32'(write_enable), 32'd0);
        check("t1_c3_pending", 32'(pending), 32'd0);
        check("t1_c3_qhit", 32'(query_hit), 32'd0);
        check("t1_c3_addr_hold", 32'(write_addr), 32'd5);
        check("t1_c3_data_hold", write_data, 32'h1234_5678);

        // All four sources at once from pointer 0
        do_reset();
        for (int s = 0; s < 4; s++) push(s, 5'(s + 1), 32'hA000_0000 + 32'(s), 1'b0, 1'b1);
        step(); idle();
        for (int c = 0; c < 5; c++) begin
            check("t2_stall", 32'(stall), 32'd0);
            step();
        end
        wait_drain("t2");
        // Pointer should be back at alu: alu wins over fpu
        push(1, 5'd11, 32'hB000_0011, 1'b0, 1'b0);
        push(0, 5'd10, 32'hB000_0010, 1'b0, 1'b0);
        sb.push_back(wr_t'{5'd10, 32'hB000_0010, 1'b0});
        sb.push_back(wr_t'{5'd11, 32'hB000_0011, 1'b0});
        step(); idle();
        wait_drain("t2b");

        // Stall with alu flooding and fpu pushing three cycles
        do_reset();
        for (int c = 0; c < 6; c++) begin
            push(0, 5'(6 + c), 32'hC000_0000 + 32'(c), 1'b0, 1'b1);
            if (c < 3) push(1, 5'(16 + c), 32'hCF00_0000 + 32'(c), 1'b1, 1'b1);
            step(); idle();
            if (c == 0) check("t3_stall_e1", 32'(stall), 32'd0);
            if (c == 1) check("t3_stall_e2", 32'(stall), 32'd1);
            if (c == 2) check("t3_stall_e3", 32'(stall), 32'd1);
        end
        wait_drain("t3");
        check("t3_stall_end", 32'(stall), 32'd0);
        check("t3_overflow", 32'(overflow), 32'd0);

        // Integer r0 is discarded; float f0 is written
        push(0, 5'd0, 32'hDEAD_0000, 1'b0, 1'b0);
        step(); idle();
        check("t4_r0_pending1", 32'(pending), 32'd0);
        step();
        check("t4_r0_we", 32'(write_enable), 32'd0);
        check("t4_r0_pending2", 32'(pending), 32'd0);
        query_addr = 5'd0; query_float = 1'b1;
        push(0, 5'd0, 32'h0000_F0F0, 1'b1, 1'b1);
        step(); idle();
        check("t4_f0_qhit", 32'(query_hit), 32'd1);
        step();
        check("t4_f0_we", 32'(write_enable), 32'd1);
        check("t4_f0_float", 32'(write_float), 32'd1);
        query_float = 1'b0;
        #1;
        check("t4_r0_query", 32'(query_hit), 32'd0);
        wait_drain("t4");

        // All sources flood five cycles, then mem pushes into its full FIFO
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c < 5) begin
                for (int s = 0; s < 4; s++)
                    push(s, 5'(1 + s * 5 + c), 32'hE000_0000 + 32'(s * 16 + c), 1'b0, 1'b1);
            end else begin
                push(2, 5'd31, 32'hBAD0_BAD0, 1'b0, 1'b0);
            end
            step(); idle();
            if (c < 5) check("t5_overflow_pre", 32'(overflow), 32'd0);
            else       check("t5_overflow_set", 32'(overflow), 32'd1);
        end
        check("t5_stall", 32'(stall), 32'd1);
        wait_drain("t5");
        check("t5_overflow_sticky", 32'(overflow), 32'd1);

        // Reset with three entries queued discards them
        push(0, 5'd7, 32'hF000_0007, 1'b0, 1'b0);
        push(1, 5'd8, 32'hF000_0008, 1'b0, 1'b0);
        push(2, 5'd9, 32'hF000_0009, 1'b0, 1'b0);
        step(); idle();
        check("t6_pending_pre", 32'(pending), 32'd1);
        do_reset();
        check("t6_we", 32'(write_enable), 32'd0);
        check("t6_pending", 32'(pending), 32'd0);
        check("t6_stall", 32'(stall), 32'd0);
        check("t6_overflow", 32'(overflow), 32'd0);
        for (int c = 0; c < 6; c++) step();
        check("t6_pending_end", 32'(pending), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
